// File: rtl/button_event.sv
// Turns a debounced button level into tap / long-press / auto-repeat events on a
// valid/ack handshake. Events raised while one is still pending are dropped and counted.
module button_event #(
  parameter int unsigned LONG_CYCLES   = 1024,
  parameter int unsigned REPEAT_CYCLES = 256,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       m_clock,
  input  logic       m_reset_n,
  input  logic       m_state,
  input  logic       m_ack,
  output logic       m_event_valid,
  output logic       m_event_long,
  output logic       m_pressed,
  output logic [7:0] m_drop_count
);

  typedef enum logic [1:0] {StIdle, StHeld, StLong} state_e;

  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_next;
  logic [CNT_W-1:0] r_rep_cnt, w_rep_next;
  logic             r_prev;
  logic             r_valid, w_valid_next;
  logic             r_long, w_long_next;
  logic             r_pressed;
  logic [7:0]       r_drop, w_drop_next;
  logic             w_emit, w_emit_long;

  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    w_rep_next   = r_rep_cnt;
    w_emit       = 1'b0;
    w_emit_long  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Press edge: level low now, high on the previous edge.
        if (!m_state && r_prev) begin
          w_state_next = StHeld;
          w_hold_next  = '0;
        end
      end
      StHeld: begin
        if (m_state) begin
          w_emit       = 1'b1;
          w_state_next = StIdle;
        end else if (r_hold_cnt == LongLast) begin
          w_emit       = 1'b1;
          w_emit_long  = 1'b1;
          w_state_next = StLong;
          w_rep_next   = '0;
        end else begin
          w_hold_next = r_hold_cnt + 1'b1;
        end
      end
      StLong: begin
        if (m_state) begin
          w_state_next = StIdle;
        end else if (r_rep_cnt == RepeatLast) begin
          w_emit      = 1'b1;
          w_emit_long = 1'b1;
          w_rep_next  = '0;
        end else begin
          w_rep_next = r_rep_cnt + 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_valid_next = r_valid;
    w_long_next  = r_long;
    w_drop_next  = r_drop;
    if (w_emit) begin
      // An ack on the same edge frees the slot, so the new event replaces the old one.
      if (!r_valid || m_ack) begin
        w_valid_next = 1'b1;
        w_long_next  = w_emit_long;
      end else if (r_drop != 8'hFF) begin
        w_drop_next = r_drop + 8'd1;
      end
    end else if (r_valid && m_ack) begin
      w_valid_next = 1'b0;
    end
  end

  always_ff @(posedge m_clock or negedge m_reset_n) begin
    if (!m_reset_n) begin
      r_state    <= StIdle;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_prev     <= 1'b1;
      r_valid    <= 1'b0;
      r_long     <= 1'b0;
      r_pressed  <= 1'b0;
      r_drop     <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      r_rep_cnt  <= w_rep_next;
      r_prev     <= m_state;
      r_valid    <= w_valid_next;
      r_long     <= w_long_next;
      r_pressed  <= (w_state_next != StIdle);
      r_drop     <= w_drop_next;
    end
  end

  assign m_event_valid = r_valid;
  assign m_event_long  = r_long;
  assign m_pressed     = r_pressed;
  assign m_drop_count  = r_drop;

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: directed scenarios plus random button/ack
// traffic, all compared against a press-duration based reference model.
module tb_button_event;

  localparam int unsigned LongCycles   = 8;
  localparam int unsigned RepeatCycles = 4;

  logic       m_clock;
  logic       m_reset_n;
  logic       m_state;
  logic       m_ack;
  logic       m_event_valid;
  logic       m_event_long;
  logic       m_pressed;
  logic [7:0] m_drop_count;

  int n_checks;
  int n_fails;

  // Reference model: tracks how many edges the button has been down since the
  // press was recognised, and derives events from that duration directly.
  bit md_pressed;
  int md_k;
  bit md_prev;
  bit md_valid;
  bit md_long;
  int md_drop;

  button_event #(
    .LONG_CYCLES  (LongCycles),
    .REPEAT_CYCLES(RepeatCycles),
    .CNT_W        (16)
  ) dut (
    .m_clock      (m_clock),
    .m_reset_n    (m_reset_n),
    .m_state      (m_state),
    .m_ack        (m_ack),
    .m_event_valid(m_event_valid),
    .m_event_long (m_event_long),
    .m_pressed    (m_pressed),
    .m_drop_count (m_drop_count)
  );

  initial m_clock = 1'b0;
  always #5 m_clock = ~m_clock;

  task automatic model_reset();
    md_pressed = 0; md_k = 0; md_prev = 1; md_valid = 0; md_long = 0; md_drop = 0;
  endtask

  task automatic model_step(input bit st, input bit ack);
    bit emit;
    bit typ;
    emit = 0;
    typ  = 0;
    if (!md_pressed) begin
      if (!st && md_prev) begin
        md_pressed = 1;
        md_k       = 0;
      end
    end else begin
      md_k++;
      if (st) begin
        md_pressed = 0;
        if (md_k <= int'(LongCycles)) emit = 1;
      end else if (md_k >= int'(LongCycles) &&
                   (md_k - int'(LongCycles)) % int'(RepeatCycles) == 0) begin
        emit = 1;
        typ  = 1;
      end
    end
    if (emit) begin
      if (!md_valid || ack) begin
        md_valid = 1;
        md_long  = typ;
      end else if (md_drop < 255) begin
        md_drop++;
      end
    end else if (md_valid && ack) begin
      md_valid = 0;
    end
    md_prev = st;
  endtask

  task automatic tick(input bit st, input bit ack);
    m_state = st;
    m_ack   = ack;
    @(posedge m_clock);
    model_step(st, ack);
    #1;
  endtask

  task automatic test_reset();
    m_reset_n = 1'b0;
    m_state   = 1'b1;
    m_ack     = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({m_event_valid, m_event_long, m_pressed, m_drop_count} !== 11'd0) begin
      n_fails++;
      $display("FAIL reset_outputs: got v=%b l=%b p=%b d=%0d, want all 0",
               m_event_valid, m_event_long, m_pressed, m_drop_count);
    end
    repeat (2) @(posedge m_clock);
    #2 m_reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1, 1);
      n_checks++;
      if (m_event_valid !== 1'b0 || m_drop_count !== 8'd0 || m_pressed !== 1'b0) begin
        n_fails++;
        $display("FAIL idle cycle %0d: got v=%b p=%b d=%0d, want v=0 p=0 d=0",
                 i, m_event_valid, m_pressed, m_drop_count);
      end
    end
  endtask

  task automatic test_short_tap();
    int pressed_cycles;
    int valid_cycles;
    pressed_cycles = 0;
    valid_cycles   = 0;
    for (int i = 0; i < 10; i++) begin
      tick((i < 3) ? 1'b0 : 1'b1, 1'b1);
      if (m_pressed) pressed_cycles++;
      if (m_event_valid) valid_cycles++;
      n_checks++;
      if ({m_event_valid, m_event_valid & m_event_long, m_pressed, m_drop_count} !==
          {md_valid, md_valid & md_long, md_pressed, 8'(md_drop)}) begin
        n_fails++;
        $display("FAIL short_tap cycle %0d: got v=%b l=%b p=%b d=%0d, want v=%b l=%b p=%b d=%0d",
                 i, m_event_valid, m_event_long, m_pressed, m_drop_count,
                 md_valid, md_long, md_pressed, md_drop);
      end
    end
    n_checks++;
    if (pressed_cycles != 3 || valid_cycles != 1) begin
      n_fails++;
      $display("FAIL short_tap_counts: got pressed=%0d valid=%0d, want 3 and 1",
               pressed_cycles, valid_cycles);
    end
  endtask

  task automatic test_long_repeat();
    int long_events;
    long_events = 0;
    for (int i = 0; i < 26; i++) begin
      tick((i < 20) ? 1'b0 : 1'b1, 1'b1);
      if (m_event_valid && m_event_long) long_events++;
      n_checks++;
      if ({m_event_valid, m_event_valid & m_event_long, m_pressed, m_drop_count} !==
          {md_valid, md_valid & md_long, md_pressed, 8'(md_drop)}) begin
        n_fails++;
        $display("FAIL long_repeat cycle %0d: got v=%b l=%b p=%b d=%0d, want v=%b l=%b p=%b d=%0d",
                 i, m_event_valid, m_event_long, m_pressed, m_drop_count,
                 md_valid, md_long, md_pressed, md_drop);
      end
      // Long after entry edge (i=0) + 8, repeats at +12 and +16.
      if (i == 8 || i == 12 || i == 16) begin
        n_checks++;
        if (m_event_valid !== 1'b1 || m_event_long !== 1'b1) begin
          n_fails++;
          $display("FAIL long_timing edge %0d: got v=%b l=%b, want v=1 l=1",
                   i, m_event_valid, m_event_long);
        end
      end
    end
    n_checks++;
    if (long_events != 3) begin
      n_fails++;
      $display("FAIL long_event_count: got %0d, want 3", long_events);
    end
  endtask

  task automatic test_drop();
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 5; i++) tick((i < 3) ? 1'b0 : 1'b1, 1'b0);
    end
    n_checks++;
    if (m_event_valid !== 1'b1 || m_event_long !== 1'b0 || m_drop_count !== 8'd1) begin
      n_fails++;
      $display("FAIL drop_pending: got v=%b l=%b d=%0d, want v=1 l=0 d=1",
               m_event_valid, m_event_long, m_drop_count);
    end
    tick(1, 1);
    tick(1, 0);
    n_checks++;
    if (m_event_valid !== 1'b0 || m_drop_count !== 8'(md_drop) || md_valid) begin
      n_fails++;
      $display("FAIL drop_ack: got v=%b d=%0d, want v=0 d=%0d", m_event_valid, m_drop_count,
               md_drop);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] drop_before;
    bit         gap;
    // Pending long event, then release with no event.
    for (int i = 0; i < 10; i++) tick((i < 9) ? 1'b0 : 1'b1, 1'b0);
    drop_before = m_drop_count;
    gap = 0;
    // Tap whose release edge carries the ack of the pending long event.
    for (int i = 0; i < 4; i++) begin
      tick((i < 3) ? 1'b0 : 1'b1, (i == 3) ? 1'b1 : 1'b0);
      if (!m_event_valid) gap = 1;
    end
    n_checks++;
    if (gap || m_event_long !== 1'b0 || m_drop_count !== drop_before) begin
      n_fails++;
      $display("FAIL replace_on_ack: got gap=%0d l=%b d=%0d, want gap=0 l=0 d=%0d",
               gap, m_event_long, m_drop_count, drop_before);
    end
    for (int t = 0; t < 260; t++) begin
      for (int i = 0; i < 4; i++) tick((i < 2) ? 1'b0 : 1'b1, 1'b0);
    end
    n_checks++;
    if (m_drop_count !== 8'd255 || md_drop != 255) begin
      n_fails++;
      $display("FAIL drop_saturate: got %0d, want 255", m_drop_count);
    end
    tick(1, 1);
  endtask

  task automatic test_reset_mid_hold();
    for (int i = 0; i < 5; i++) tick(0, 1);
    n_checks++;
    if (m_pressed !== 1'b1) begin
      n_fails++;
      $display("FAIL held_before_reset: got p=%b, want 1", m_pressed);
    end
    m_reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({m_event_valid, m_pressed, m_drop_count} !== 10'd0) begin
      n_fails++;
      $display("FAIL reset_mid_hold: got v=%b p=%b d=%0d, want all 0",
               m_event_valid, m_pressed, m_drop_count);
    end
    #3 m_reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1, 1);
      n_checks++;
      if (m_event_valid !== 1'b0 || m_pressed !== 1'b0) begin
        n_fails++;
        $display("FAIL release_after_reset cycle %0d: got v=%b p=%b, want 0 0",
                 i, m_event_valid, m_pressed);
      end
    end
  endtask

  task automatic test_random();
    bit st;
    int run;
    st  = 1;
    run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        st  = ~st;
        run = st ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 24));
      end
      run--;
      tick(st, ($urandom_range(0, 3) == 0));
      n_checks++;
      if ({m_event_valid, m_event_valid & m_event_long, m_pressed, m_drop_count} !==
          {md_valid, md_valid & md_long, md_pressed, 8'(md_drop)}) begin
        n_fails++;
        $display("FAIL random cycle %0d: got v=%b l=%b p=%b d=%0d, want v=%b l=%b p=%b d=%0d",
                 i, m_event_valid, m_event_long, m_pressed, m_drop_count,
                 md_valid, md_long, md_pressed, md_drop);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_short_tap();
    test_long_repeat();
    test_drop();
    test_back_to_back();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the button debouncer. Consumes its debounced level, where 0 means pressed and 1 means released.
- Turns the level into discrete game-control events: a short tap on release, a long press once a hold threshold is crossed, and auto-repeat events while the button stays held.
- Events are presented on a valid/ack handshake to the game FSM.
- Events that arrive while a previous event is still unacknowledged are dropped and counted.

Parameters:
- LONG_CYCLES, 1024: number of clock edges the button must be held before the first long event fires. Must be at least 2 and fit in CNT_W.
- REPEAT_CYCLES, 256: clock edges between successive repeat events while held after a long event. Must be at least 1 and fit in CNT_W.
- CNT_W, 16: width of the hold and repeat counters.

Ports:
- m_clock, in, 1: single system clock. All logic is on its rising edge.
- m_reset_n, in, 1: asynchronous, active-low reset.
- m_state, in, 1: debounced button level from the debouncer, same clock domain. 0 = pressed, 1 = released.
- m_ack, in, 1: consumer accepts the pending event. Sampled on a rising edge while m_event_valid=1.
- m_event_valid, out, 1: an event is pending.
- m_event_long, out, 1: type of the pending event. 0 = short tap, 1 = long or repeat. Meaningful only while m_event_valid=1.
- m_pressed, out, 1: registered indication that the FSM is in HELD or LONG.
- m_drop_count, out, 8: count of dropped events. Saturates at 255.

Behaviour:
- Reset (asynchronous, takes effect immediately on m_reset_n low):
  - state=IDLE, hold_cnt=0, rep_cnt=0, prev=1.
  - m_event_valid=0, m_event_long=0, m_pressed=0, m_drop_count=0.
- prev holds the previous m_state each edge.
- Press edge: m_state=0 and prev=1 at a rising edge. A button already held when reset deasserts is therefore seen as a press on the first edge.
- IDLE:
  - On a press edge: go to HELD, hold_cnt=0, m_pressed=1 after that edge.
  - Otherwise stay in IDLE.
- HELD:
  - Edge with m_state=1: emit a short event (long=0), go to IDLE, m_pressed=0.
  - Edge with m_state=0 and hold_cnt=LONG_CYCLES-1: emit a long event (long=1), go to LONG, rep_cnt=0.
  - Otherwise: hold_cnt increments.
  - Net timing: the first long event is emitted on the LONG_CYCLES-th edge after the entry edge.
- LONG:
  - Edge with m_state=1: go to IDLE, no event, m_pressed=0.
  - Edge with rep_cnt=REPEAT_CYCLES-1: emit a long event, rep_cnt=0.
  - Otherwise: rep_cnt increments.
- Counters never wrap, because the FSM leaves the counting condition at the terminal count.
- Emission, on the same edge as the emit condition:
  - If m_event_valid=0, or (m_event_valid=1 and m_ack=1): m_event_valid=1 and m_event_long=type after the edge.
    - Latency from the release edge (short) or terminal-count edge (long) to valid is 0 extra cycles; outputs are registered.
    - Emission coincident with ack replaces the pending event with no gap and no drop.
  - If m_event_valid=1 and m_ack=0: the new event is discarded, the pending event and its type are unchanged, and m_drop_count increments (saturating at 255).
- Handshake:
  - While m_event_valid=1, m_event_long is held stable until accepted.
  - Edge with m_event_valid=1, m_ack=1 and no emission: m_event_valid=0 after the edge.
  - m_ack while m_event_valid=0 is ignored.
- Reset in mid-operation (HELD or LONG): the FSM returns to IDLE immediately. A later release generates no event; a press is needed only if prev was reset to 1 while the button is held.
- No combinational path from inputs to outputs.

Test Plan (bench parameters LONG_CYCLES=8, REPEAT_CYCLES=4):
1. Reset with m_state=1 and m_ack=1 -> all outputs 0. Idle for 20 cycles -> m_event_valid stays 0, m_drop_count=0.
2. m_state=0 for 3 edges, then 1, with m_ack=1 -> m_pressed=1 for 3 cycles, then exactly one 1-cycle m_event_valid with m_event_long=0 right after the release edge.
3. Hold m_state=0 for 20 edges, then release, with m_ack=1 -> long event after the 8th edge post-entry, repeats 4 and 8 edges later (3 events total, all long=1), no event on release.
4. m_ack=0 with two taps (3-edge presses, 2-edge gaps) -> m_event_valid stays 1 with long=0, m_drop_count=1. Then ack for one edge -> valid drops next cycle.
5. Tap whose release edge coincides with the ack edge of a pending event -> m_event_valid stays 1 continuously, new type loaded, m_drop_count unchanged. Also, 260 drops -> m_drop_count=255.
6. Pulse m_reset_n low during HELD (4 edges into the hold) -> outputs 0 immediately. Release after reset deasserts -> no event.
